// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / UART loader) arbiter for a single-port data RAM.
// Round-robin grant, loader lock, and one-cycle read-response routing.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [31:0]       ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [31:0]       ldr_rdata,
  input  logic              ldr_lock,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic              last_q, last_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ldr_rdata_q, ldr_rdata_d;
  logic              cpu_elig, ldr_elig, gnt_any, gnt_we;

  // Arbitration, RAM drive and read-response routing
  always_comb begin
    cpu_gnt     = 1'b0;
    ldr_gnt     = 1'b0;
    cpu_elig    = cpu_req & ~ldr_lock & ~reset;
    ldr_elig    = ldr_req & ~reset;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    last_d      = last_q;

    // LAST = 1 means the loader was served last, so the CPU wins a tie
    if (cpu_elig && ldr_elig) begin
      cpu_gnt = last_q;
      ldr_gnt = ~last_q;
    end else begin
      cpu_gnt = cpu_elig;
      ldr_gnt = ldr_elig;
    end

    gnt_any = cpu_gnt | ldr_gnt;
    gnt_we  = ldr_gnt ? ldr_we : cpu_we;

    if (ldr_gnt) begin
      ram_addr_d  = ldr_addr[ADDR_W+1:2];
      ram_wdata_d = ldr_wdata;
      last_d      = 1'b1;
    end else if (cpu_gnt) begin
      ram_addr_d  = cpu_addr[ADDR_W+1:2];
      ram_wdata_d = cpu_wdata;
      last_d      = 1'b0;
    end

    ram_we    = gnt_any & gnt_we;
    ram_addr  = reset ? '0 : ram_addr_d;
    ram_wdata = reset ? '0 : ram_wdata_d;

    rd_pend_d  = gnt_any & ~gnt_we;
    rd_owner_d = ldr_gnt;

    cpu_rvalid = rd_pend_q & ~rd_owner_q & ~reset;
    ldr_rvalid = rd_pend_q & rd_owner_q & ~reset;

    cpu_rdata_d = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    ldr_rdata_d = ldr_rvalid ? ram_rdata : ldr_rdata_q;
    cpu_rdata   = reset ? 32'h0 : cpu_rdata_d;
    ldr_rdata   = reset ? 32'h0 : ldr_rdata_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q      <= 1'b1;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      cpu_rdata_q <= 32'h0;
      ldr_rdata_q <= 32'h0;
    end else begin
      last_q      <= last_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency RAM.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_gnt, ldr_rvalid, ldr_lock;
  logic [31:0]       ldr_addr, ldr_wdata, ldr_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [31:0] mem     [DEPTH];
  bit          written [DEPTH];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ldr_lock(ldr_lock),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Unwritten words read back as 0xA000_0000 | index
  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : (32'hA000_0000 | 32'(ram_addr));
  end

  task automatic set_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clock); set_idle(); ldr_lock = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; ldr_lock = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h10; ldr_req = 1'b1; ldr_addr = 32'h20;
    #1;
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt: got %0b want 0", cpu_gnt); end
    checks++; if (ldr_gnt !== 1'b0) begin errors++; $display("FAIL rst_ldr_gnt: got %0b want 0", ldr_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %0b want 0", ram_we); end
    @(negedge clock); #1;
    checks++; if (ram_addr !== 14'h0) begin errors++; $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %0h want 0", cpu_rdata); end
    checks++; if (ldr_rdata !== 32'h0) begin errors++; $display("FAIL rst_ldr_rdata: got %0h want 0", ldr_rdata); end
    reset = 1'b0; set_idle();
    @(negedge clock); #1;
    checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, ldr_rvalid}); end
  endtask

  task automatic test_single_read();
    @(negedge clock);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0010; #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL sr_gnt: got %0b want 1", cpu_gnt); end
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL sr_ram_addr: got %0h want 4", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL sr_ram_we: got %0b want 0", ram_we); end
    @(negedge clock); set_idle(); #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL sr_rvalid: got %0b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hA000_0004) begin errors++; $display("FAIL sr_rdata: got %0h want a0000004", cpu_rdata); end
    checks++; if (ldr_rvalid !== 1'b0) begin errors++; $display("FAIL sr_ldr_rvalid: got %0b want 0", ldr_rvalid); end
    @(negedge clock); #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL sr_rvalid_drop: got %0b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hA000_0004) begin errors++; $display("FAIL sr_rdata_hold: got %0h want a0000004", cpu_rdata); end
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL sr_addr_hold: got %0h want 4", ram_addr); end
  endtask

  task automatic test_round_robin();
    logic ldr_turn;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h20; ldr_req = 1'b1; ldr_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      ldr_turn = 1'((i % 2) == 1);
      #1;
      checks++; if ({cpu_gnt, ldr_gnt} !== {~ldr_turn, ldr_turn}) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {cpu_gnt, ldr_gnt}, {~ldr_turn, ldr_turn}); end
      checks++; if (ram_addr !== (ldr_turn ? 14'd12 : 14'd8)) begin errors++; $display("FAIL rr_addr[%0d]: got %0h want %0h", i, ram_addr, ldr_turn ? 14'd12 : 14'd8); end
      if (i > 0) begin
        checks++; if ({cpu_rvalid, ldr_rvalid} !== {ldr_turn, ~ldr_turn}) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {cpu_rvalid, ldr_rvalid}, {ldr_turn, ~ldr_turn}); end
        if (ldr_turn) begin
          checks++; if (cpu_rdata !== 32'hA000_0008) begin errors++; $display("FAIL rr_cpu_rdata[%0d]: got %0h want a0000008", i, cpu_rdata); end
        end else begin
          checks++; if (ldr_rdata !== 32'hA000_000C) begin errors++; $display("FAIL rr_ldr_rdata[%0d]: got %0h want a000000c", i, ldr_rdata); end
        end
      end
      @(negedge clock);
    end
    set_idle(); #1;
    checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b01) begin errors++; $display("FAIL rr_last_rvalid: got %b want 01", {cpu_rvalid, ldr_rvalid}); end
    checks++; if (ldr_rdata !== 32'hA000_000C) begin errors++; $display("FAIL rr_last_rdata: got %0h want a000000c", ldr_rdata); end
  endtask

  task automatic test_lock_write();
    @(negedge clock);
    ldr_lock = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h0000_0100; ldr_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({cpu_gnt, ldr_gnt} !== 2'b01) begin errors++; $display("FAIL lw_gnt[%0d]: got %b want 01", i, {cpu_gnt, ldr_gnt}); end
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL lw_we[%0d]: got %0b want 1", i, ram_we); end
      checks++; if (ram_addr !== 14'd64 || ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_bus[%0d]: got %0h/%0h want 40/deadbeef", i, ram_addr, ram_wdata); end
      checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin errors++; $display("FAIL lw_rvalid[%0d]: got %b want 00", i, {cpu_rvalid, ldr_rvalid}); end
      @(negedge clock);
    end
    ldr_lock = 1'b0; set_idle(); cpu_req = 1'b1; cpu_addr = 32'h100; #1;
    checks++; if (cpu_gnt !== 1'b1 || ram_addr !== 14'd64) begin errors++; $display("FAIL lw_rd_gnt: got %0b/%0h want 1/40", cpu_gnt, ram_addr); end
    @(negedge clock); set_idle(); #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_readback: got %0b/%0h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_lock_during_read();
    @(negedge clock);
    cpu_req = 1'b1; cpu_addr = 32'h10; #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL ldr_cpu_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clock);
    ldr_lock = 1'b1; ldr_req = 1'b1; ldr_addr = 32'h40; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA000_0004) begin errors++; $display("FAIL ldr_cpu_rvalid: got %0b/%0h want 1/a0000004", cpu_rvalid, cpu_rdata); end
    checks++; if ({cpu_gnt, ldr_gnt} !== 2'b01) begin errors++; $display("FAIL ldr_lock_gnt: got %b want 01", {cpu_gnt, ldr_gnt}); end
    checks++; if (ram_addr !== 14'd16) begin errors++; $display("FAIL ldr_lock_addr: got %0h want 10", ram_addr); end
    @(negedge clock); set_idle(); ldr_lock = 1'b0; #1;
    checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b01 || ldr_rdata !== 32'hA000_0010) begin errors++; $display("FAIL ldr_ldr_rvalid: got %b/%0h want 01/a0000010", {cpu_rvalid, ldr_rvalid}, ldr_rdata); end
  endtask

  task automatic test_reset_during_read();
    @(negedge clock);
    cpu_req = 1'b1; cpu_addr = 32'h10; #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rdr_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clock); set_idle(); reset = 1'b1; #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rdr_rvalid: got %0b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rdr_rdata: got %0h want 0", cpu_rdata); end
    @(negedge clock);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h20; ldr_req = 1'b1; ldr_addr = 32'h30; #1;
    checks++; if ({cpu_gnt, ldr_gnt} !== 2'b10) begin errors++; $display("FAIL rdr_first_win: got %b want 10", {cpu_gnt, ldr_gnt}); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rdr_no_stale: got %0b want 0", cpu_rvalid); end
    @(negedge clock); set_idle(); #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA000_0008) begin errors++; $display("FAIL rdr_after: got %0b/%0h want 1/a0000008", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_addr_wrap();
    @(negedge clock);
    cpu_req = 1'b1; cpu_addr = 32'hFFFF_FFFC; #1;
    checks++; if (cpu_gnt !== 1'b1 || ram_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_addr: got %0b/%0h want 1/3fff", cpu_gnt, ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wrap_we: got %0b want 0", ram_we); end
    @(negedge clock); set_idle(); #1;
    checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b10 || cpu_rdata !== 32'hA000_3FFF) begin errors++; $display("FAIL wrap_read: got %b/%0h want 10/a0003fff", {cpu_rvalid, ldr_rvalid}, cpu_rdata); end
    checks++; if (ram_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_hold: got %0h want 3fff", ram_addr); end
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8001_0023; cpu_wdata = 32'h1234_5678; #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 14'd8 || ram_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wrap_wr: got %0b/%0h/%0h want 1/8/12345678", ram_we, ram_addr, ram_wdata); end
    @(negedge clock);
    cpu_we = 1'b0; cpu_addr = 32'h20; #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wrap_wr_rvalid: got %0b want 0", cpu_rvalid); end
    @(negedge clock); set_idle(); #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wrap_readback: got %0b/%0h want 1/12345678", cpu_rvalid, cpu_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ldr_lock = 1'b0; set_idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_write();
    test_lock_during_read();
    test_reset_during_read();
    test_addr_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the RAM word-address width (RAM word index = byte address bits [ADDR_W+1:2]).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU access request, level, held until granted.
REQ-005 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_addr  in  32  CPU byte address.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
REQ-010 cpu_rdata  out  32  CPU read data.
REQ-011 ldr_req, ldr_we, ldr_addr[31:0], ldr_wdata[31:0]  in  UART loader request bundle, same semantics as the CPU bundle.
REQ-012 ldr_gnt, ldr_rvalid  out  1 each; ldr_rdata  out  32  loader grant and response, same semantics as the CPU signals.
REQ-013 ldr_lock  in  1  1 = loader has exclusive access and CPU requests are never granted.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_addr  out  ADDR_W  RAM word address.
REQ-016 ram_wdata  out  32  RAM write data.
REQ-017 ram_rdata  in  32  RAM read data, valid the cycle after the address is presented.

Function
REQ-018 At most one grant SHALL be asserted per cycle; a grant SHALL only be asserted in a cycle where the matching req is 1.
REQ-019 Grant SHALL be combinational in the request cycle; ram_we/ram_addr/ram_wdata SHALL be driven from the granted requester in that same cycle.
REQ-020 With no grant, ram_we SHALL be 0, and ram_addr/ram_wdata SHALL hold their previous values.
REQ-021 ram_addr SHALL be taken from addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 SHALL be ignored, so out-of-range addresses wrap.
REQ-022 Arbitration SHALL be round-robin via a 1-bit register LAST (0 = CPU, 1 = LDR), updated to the granted requester on every grant.
REQ-023 When both requesters are eligible, the one not equal to LAST SHALL win; a single eligible requester SHALL win immediately.
REQ-024 When ldr_lock = 1, the CPU SHALL be ineligible; the loader SHALL be granted whenever ldr_req = 1.
REQ-025 A granted read SHALL produce an rvalid pulse to that requester exactly 1 cycle later, with rdata = ram_rdata in that cycle; a pending-owner register SHALL record the target.
REQ-026 A granted write SHALL produce no rvalid; the write SHALL take effect in the grant cycle.
REQ-027 Back-to-back grants SHALL be allowed every cycle, including a read followed by an access from the other requester; rvalid SHALL still route to the original reader.
REQ-028 A change of ldr_lock SHALL NOT cancel a read already granted; its rvalid SHALL still be delivered.
REQ-029 cpu_rdata and ldr_rdata SHALL hold their last delivered value when rvalid = 0.

Reset
REQ-030 While reset = 1, there SHALL be no grants, ram_we SHALL be 0, and rvalid (both) SHALL be 0.
REQ-031 On reset, LAST SHALL be 1 (the CPU wins the first contention), the pending read SHALL be cleared, rdata (both) SHALL be 0, and ram_addr/ram_wdata SHALL be 0.
REQ-032 A read granted in the cycle reset asserts SHALL produce no rvalid.

Verification
REQ-033 After reset, cpu_req = 1, cpu_we = 0, cpu_addr = 0x0000_0010 -> cpu_gnt = 1 and ram_addr = 4 in the same cycle; the next cycle cpu_rvalid = 1 and cpu_rdata = RAM word 4.
REQ-034 After reset, with cpu_req and ldr_req held at 1 (reads) for 4 cycles -> grants go CPU, LDR, CPU, LDR; each rvalid arrives at the correct requester one cycle after its grant.
REQ-035 With ldr_lock = 1, both requesting, and ldr_we = 1 writing 0xDEAD_BEEF to 0x0000_0100 -> only ldr_gnt is asserted, ram_we = 1, ram_addr = 64, and cpu_gnt stays 0 for 3 cycles.
REQ-036 A CPU read is granted, then ldr_lock rises in the next cycle -> cpu_rvalid is still asserted in that cycle, and the loader is granted in the same cycle.
REQ-037 A CPU read is granted, then reset is asserted in the next cycle -> cpu_rvalid = 0, cpu_rdata = 0, and the next contention after release is won by the CPU.
REQ-038 cpu_addr = 0xFFFF_FFFC -> ram_addr = all ones (wrap) and no other side effect.
